fix2sfp_pipe: RTL and testbench
===============================

# fix2sfp_pipe

Pipelined, handshaked converter from two's-complement fixed-point accumulator sums to the packed SFP format (sign | exponent | mantissa, hidden leading one). It sits after the fixed-point adder trees in the Hadamard/FFT datapath and replaces the combinational converter. It adds several things the combinational converter lacks: full-range negative handling, round-to-nearest-even, exponent saturation and underflow flushing with flags, and valid/ready back-pressure.

## Interface
- expWidth, 4, exponent field width
- sigWidth, 4, stored mantissa width (hidden one excluded)
- formatWidth, 9, output width; must equal 1+expWidth+sigWidth
- low_expand, 2, guard bits below the mantissa LSB in the fixed-point input
- Derived: FIX_W = sigWidth+4+low_expand (input width); MAG_W = FIX_W-1
- clk  in  1  clock, all state on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input word valid
- in_ready  out  1  converter accepts the word this cycle
- fixin  in  FIX_W  signed two's-complement sum
- max_exp  in  expWidth  block exponent, captured with fixin
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- sfpout  out  formatWidth  {sign, exp, mant}
- ovf  out  1  exponent saturated (qualified by out_valid)
- unf  out  1  nonzero result flushed to zero (qualified by out_valid)

## Operation
- Input value = fixin · 2^(max_exp − sigWidth − low_expand), scaled so that the input LSB carries the exponent offset.
- Stage 1:
  - zero = (fixin == 0); sign = fixin[MSB] & ~zero.
  - Magnitude M is MAG_W+1 bits wide, so the most negative input (e.g. 0x200) gives M = 2^MAG_W with no wrap.
  - Register max_exp.
- Stage 2:
  - L = index of the leading one of M.
  - E = max_exp + L − sigWidth − low_expand, computed signed with expWidth+2 bits.
- Stage 3: normalise and round.
  - mant = M[L−1 −: sigWidth].
  - If L < sigWidth, zero-fill the missing low bits; no rounding is applied.
  - Remainder bits below mant feed the rounding step.
  - Rounding carry-out gives mant = 0 and E = E+1.
- Exponent handling:
  - E > 2^expWidth−1: exp = all ones, mant = all ones, sign kept, ovf = 1.
  - E < 0: sfpout = 0, unf = 1.
  - Otherwise exp = E[expWidth−1:0].
- Zero input: sfpout = 0, ovf = unf = 0.

## Timing
- Three register stages; latency is 3 cycles from the input handshake to out_valid.
- Throughput is 1 word/cycle.
- Global advance: adv = ~out_valid | out_ready; in_ready = adv.
  - All stages shift together on adv.
  - Bubbles do not collapse.
- Transfers occur on valid & ready at the rising edge.
- While out_valid=1 and out_ready=0, sfpout, ovf and unf hold stable.
- Simultaneous accept and emit in the same cycle is supported with no loss or duplication.
- Reset:
  - Async assertion clears all stage valids, so out_valid=0, sfpout=0, ovf=unf=0 and in_ready=1 once out_valid is low.
  - In-flight words are dropped.
  - The first accepted word after rst_n deasserts appears exactly 3 cycles later.
- Data registers capture only when their valid is set (enable gating).

## Configuration
- FIX2SFP_ROUND_EN defined: round-to-nearest-even on the remainder bits (guard = first remainder bit, sticky = OR of the rest).
  - The carry-out of rounding can trigger ovf.
- FIX2SFP_ROUND_EN undefined: truncation (remainder discarded) with identical latency; ovf arises only from E.

## Structure
- Package fix2sfp_pkg holds:
  - FIX_W, MAG_W and L-width (clog2(MAG_W+1)) functions.
  - A stage payload struct {sign, zero, mag/mant, exp_signed}.
  - The saturation constants.
- One sub-module, lzd_enc: parametrised leading-one priority encoder (MAG_W+1 inputs, outputs L and an all-zero indication), instantiated in stage 2.

## Test plan
Defaults throughout (FIX_W=10). Results with FIX2SFP_ROUND_EN unless noted.
- Basic conversion: fixin=176, max_exp=5 → sfpout=0x066. fixin=0x350 (−176), max_exp=5 → 0x166. Flags are 0 and latency is 3 cycles.
- Rounding: fixin=188, max_exp=5 → 0x068 with macro, 0x067 without. fixin=180 (tie, even) → 0x066. fixin=252 → 0x070 (carry into exp) with macro, 0x06F without.
- Range limits:
  - fixin=0x200, max_exp=5 → 0x180.
  - fixin=176, max_exp=15 → 0x0FF with ovf=1.
  - fixin=1, max_exp=0 → 0x000 with unf=1.
  - fixin=0 → 0x000 with flags 0.
- Back-pressure: 16 random words with random in_valid and out_ready toggling → the output sequence equals the reference-model sequence in order, with no drop or duplicate, and outputs stay stable while stalled.
- Reset mid-stream: assert rst_n=0 with 3 words in flight → out_valid=0 asynchronously. After release, a new word appears at 3 cycles and none of the old words are emitted.

Source files
------------

// File: rtl/fix2sfp_pipe_pkg.sv
// fix2sfp_pkg: shared widths, stage payload type and saturation constants
// for the fix2sfp_pipe converter.
//   fix_w/mag_w/l_w : derived widths from sigWidth/low_expand.
//   stage_t         : per-stage payload {sign, zero, mag, exp_s}, sized
//                     from the default widths below.
package fix2sfp_pkg;

  localparam int EXP_W   = 4;
  localparam int SIG_W   = 4;
  localparam int LOW_EXP = 2;

  function automatic int fix_w(input int sig_w, input int low_exp);
    return sig_w + 4 + low_exp;
  endfunction

  function automatic int mag_w(input int sig_w, input int low_exp);
    return fix_w(sig_w, low_exp) - 1;
  endfunction

  // Width of a leading-one index over MAG_W+1 magnitude bits.
  function automatic int l_w(input int mw);
    return $clog2(mw + 1);
  endfunction

  localparam int FIX_WD = fix_w(SIG_W, LOW_EXP);
  localparam int MAG_WD = mag_w(SIG_W, LOW_EXP);
  localparam int ESW    = EXP_W + 2;

  typedef struct packed {
    logic                  sign;
    logic                  zero;
    logic [MAG_WD:0]       mag;
    logic signed [ESW-1:0] exp_s;
  } stage_t;

  localparam logic [EXP_W-1:0] EXP_SAT  = '1;
  localparam logic [SIG_W-1:0] MANT_SAT = '1;

endpackage

// File: rtl/fix2sfp_pipe_if.sv
// fix2sfp_pipe_if: valid/ready stream bundle for the converter.
//   master : producer of fixin/max_exp and consumer of sfpout/flags.
//   slave  : the converter.
interface fix2sfp_pipe_if import fix2sfp_pkg::*; #(
  parameter int FIX_W = FIX_WD,
  parameter int EXP_W_P = EXP_W,
  parameter int FMT_W = 1 + EXP_W + SIG_W
);
  logic               in_valid;
  logic               in_ready;
  logic [FIX_W-1:0]   fixin;
  logic [EXP_W_P-1:0] max_exp;
  logic               out_valid;
  logic               out_ready;
  logic [FMT_W-1:0]   sfpout;
  logic               ovf;
  logic               unf;

  modport master (
    output in_valid, fixin, max_exp, out_ready,
    input  in_ready, out_valid, sfpout, ovf, unf
  );

  modport slave (
    input  in_valid, fixin, max_exp, out_ready,
    output in_ready, out_valid, sfpout, ovf, unf
  );
endinterface

// File: rtl/fix2sfp_pipe_lzd_enc.sv
// lzd_enc: leading-one priority encoder.
//   vec_i  : N-bit input vector
//   idx_o  : index of the most significant set bit (0 when vec_i is 0)
//   zero_o : vec_i is all zeros
module lzd_enc #(
  parameter int N  = 10,
  parameter int LW = 4
) (
  input  logic [N-1:0]  vec_i,
  output logic [LW-1:0] idx_o,
  output logic          zero_o
);
  always_comb begin
    idx_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (vec_i[i]) idx_o = LW'(i);
    end
    zero_o = ~|vec_i;
  end
endmodule

// File: rtl/fix2sfp_pipe.sv
// fix2sfp_pipe: 3-stage handshaked fixed-point to SFP converter.
//   clk, rst_n : clock, async active-low reset
//   bus        : fix2sfp_pipe_if.slave (in_valid/in_ready/fixin/max_exp,
//                out_valid/out_ready/sfpout/ovf/unf)
// Build option: FIX2SFP_ROUND_EN selects round-to-nearest-even on the
// remainder bits; otherwise the remainder is truncated.
module fix2sfp_pipe import fix2sfp_pkg::*; #(
  parameter int expWidth    = EXP_W,
  parameter int sigWidth    = SIG_W,
  parameter int formatWidth = 1 + EXP_W + SIG_W,
  parameter int low_expand  = LOW_EXP
) (
  input logic           clk,
  input logic           rst_n,
  fix2sfp_pipe_if.slave bus
);
  localparam int MW  = mag_w(sigWidth, low_expand);
  localparam int LW  = l_w(MW);
  localparam int EW2 = expWidth + 2;
  localparam logic signed [EW2-1:0] E_MAX = EW2'((1 << expWidth) - 1);

  logic                  adv;
  logic                  v1_q, v2_q, v3_q;
  stage_t                s1_q, s1_d, s2_q, s2_d;
  logic [LW-1:0]         l2_q, l2_d;
  logic                  lzd_zero;
  logic [formatWidth-1:0] sfp_q, sfp_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d;

  // Whole pipe moves as one; a stalled output freezes every stage.
  assign adv          = ~v3_q | bus.out_ready;
  assign bus.in_ready = adv;

  // Stage 1: sign/zero detect and magnitude (one bit wider than the
  // payload so the most negative input does not wrap).
  always_comb begin
    s1_d       = '0;
    s1_d.zero  = (bus.fixin == '0);
    s1_d.sign  = bus.fixin[MW] & ~s1_d.zero;
    s1_d.mag   = s1_d.sign ? -bus.fixin : bus.fixin;
    s1_d.exp_s = EW2'(bus.max_exp);
  end

  // Stage 2: leading-one position and unbiased exponent.
  lzd_enc #(.N(MW + 1), .LW(LW)) u_lzd (
    .vec_i  (s1_q.mag),
    .idx_o  (l2_d),
    .zero_o (lzd_zero)
  );

  always_comb begin
    s2_d       = s1_q;
    s2_d.zero  = lzd_zero;
    s2_d.exp_s = s1_q.exp_s + EW2'(l2_d) - EW2'(sigWidth + low_expand);
  end

  // Stage 3: normalise so the hidden one lands just above the kept
  // bits (it is dropped by the cast), then round and range-check.
  logic [LW-1:0]         sh;
  logic [MW-1:0]         norm;
  logic [sigWidth-1:0]   mant_r;
  logic                  carry;
  logic signed [EW2-1:0] e3;

`ifdef FIX2SFP_ROUND_EN
  logic [sigWidth-1:0] mant;
  logic                guard, sticky;
  always_comb begin
    sh     = LW'(MW) - l2_q;
    norm   = MW'(s2_q.mag << sh);
    mant   = norm[MW-1 -: sigWidth];
    guard  = norm[MW-sigWidth-1];
    sticky = |norm[MW-sigWidth-2:0];
    {carry, mant_r} = {1'b0, mant} + (sigWidth + 1)'(guard & (sticky | mant[0]));
  end
`else
  always_comb begin
    sh     = LW'(MW) - l2_q;
    norm   = MW'(s2_q.mag << sh);
    mant_r = sigWidth'(norm >> (MW - sigWidth));
    carry  = 1'b0;
  end
`endif

  always_comb begin
    e3    = s2_q.exp_s + EW2'(carry);
    sfp_d = '0;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    if (s2_q.zero) begin
      sfp_d = '0;
    end else if (e3 > E_MAX) begin
      sfp_d = {s2_q.sign, EXP_SAT, MANT_SAT};
      ovf_d = 1'b1;
    end else if (e3 < 0) begin
      unf_d = 1'b1;
    end else begin
      sfp_d = {s2_q.sign, e3[expWidth-1:0], mant_r};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      s1_q  <= '0;
      s2_q  <= '0;
      l2_q  <= '0;
      sfp_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (adv) begin
      v1_q <= bus.in_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
      if (bus.in_valid) s1_q <= s1_d;
      if (v1_q) begin
        s2_q <= s2_d;
        l2_q <= l2_d;
      end
      if (v2_q) begin
        sfp_q <= sfp_d;
        ovf_q <= ovf_d;
        unf_q <= unf_d;
      end
    end
  end

  assign bus.out_valid = v3_q;
  assign bus.sfpout    = sfp_q;
  assign bus.ovf       = ovf_q;
  assign bus.unf       = unf_q;

endmodule

// File: tb/tb_fix2sfp_pipe.sv
// Bench for fix2sfp_pipe: arithmetic reference model, scoreboard checked
// at every negedge while out_valid, directed literal vectors, random
// back-pressure run and a mid-stream reset.
module tb_fix2sfp_pipe;

`ifdef FIX2SFP_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif
  localparam int SIG = 4;
  localparam int LOW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fix2sfp_pipe_if bus ();

  fix2sfp_pipe dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp_v);
    end
  endtask

  // Returns {ovf, unf, sfpout}.
  function automatic logic [10:0] model(input logic [9:0] fx, input logic [3:0] me);
    int v, m, L, e, q, sh, rem, half;
    logic s;
    v = int'($signed(fx));
    if (v == 0) return 11'h000;
    s = (v < 0);
    m = s ? -v : v;
    L = 0;
    while ((m >> (L + 1)) != 0) L++;
    e = int'(me) + L - SIG - LOW;
    if (L >= SIG) begin
      sh  = L - SIG;
      q   = m >> sh;
      rem = m - (q << sh);
      if (RND && sh > 0) begin
        half = 1 << (sh - 1);
        if (rem > half || (rem == half && (q % 2) == 1)) q++;
      end
      if (q == (1 << (SIG + 1))) begin
        q = q >> 1;
        e++;
      end
    end else begin
      q = m << (SIG - L);
    end
    if (e > 15) return {1'b1, 1'b0, s, 4'hF, 4'hF};
    if (e < 0) return {1'b0, 1'b1, 9'h000};
    return {2'b00, s, e[3:0], q[3:0]};
  endfunction

  logic [10:0] sb[$];
  logic        stall_hold = 1'b0;
  logic [10:0] held_w;

  // Scoreboard: compares whenever out_valid, pops on out_ready, and
  // checks that a stalled output stays put.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      stall_hold = 1'b0;
    end else begin
      if (stall_hold) begin
        check("stall_valid", int'(bus.out_valid), 1);
        check("stall_data", int'({bus.ovf, bus.unf, bus.sfpout}), int'(held_w));
      end
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          check("spurious_out", int'({bus.ovf, bus.unf, bus.sfpout}), -1);
        end else begin
          check("sb_out", int'({bus.ovf, bus.unf, bus.sfpout}), int'(sb[0]));
          if (bus.out_ready) void'(sb.pop_front());
        end
        stall_hold = !bus.out_ready;
        held_w     = {bus.ovf, bus.unf, bus.sfpout};
      end else begin
        stall_hold = 1'b0;
      end
      if (bus.in_valid && bus.in_ready) sb.push_back(model(bus.fixin, bus.max_exp));
    end
  end

  // Called at posedge+1 with an empty pipe and out_ready=1.
  task automatic run_vec(input string nm, input logic [9:0] fx, input logic [3:0] me,
                         input logic [10:0] exp_w);
    int lat;
    check({nm, "/model"}, int'(model(fx, me)), int'(exp_w));
    bus.fixin    = fx;
    bus.max_exp  = me;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({nm, "/latency"}, lat, 3);
    check({nm, "/out"}, int'({bus.ovf, bus.unf, bus.sfpout}), int'(exp_w));
  endtask

  initial begin
    int   sent;
    int   cnt;
    logic fired;
    bus.in_valid  = 1'b0;
    bus.fixin     = '0;
    bus.max_exp   = '0;
    bus.out_ready = 1'b0;

    #1;
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_sfpout", int'(bus.sfpout), 0);
    check("rst_ovf", int'(bus.ovf), 0);
    check("rst_unf", int'(bus.unf), 0);
    check("rst_in_ready", int'(bus.in_ready), 1);
    #21;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;

    run_vec("pos176",  10'd176,  4'd5,  11'h066);
    run_vec("neg176",  10'h350,  4'd5,  11'h166);
    run_vec("rnd188",  10'd188,  4'd5,  RND ? 11'h068 : 11'h067);
    run_vec("tie180",  10'd180,  4'd5,  11'h066);
    run_vec("carry252", 10'd252, 4'd5,  RND ? 11'h070 : 11'h06F);
    run_vec("carry_ovf", 10'd252, 4'd14, RND ? 11'h4FF : 11'h0FF);
    run_vec("most_neg", 10'h200, 4'd5,  11'h180);
    run_vec("ovf",     10'd176,  4'd15, 11'h4FF);
    run_vec("unf",     10'd1,    4'd0,  11'h200);
    run_vec("zero",    10'd0,    4'd9,  11'h000);
    run_vec("small_l", 10'd3,    4'd15, 11'h0A8);

    // Random back-pressure run.
    sent = 0;
    for (int cyc = 0; cyc < 400 && sent < 16; cyc++) begin
      if (!bus.in_valid && $urandom_range(0, 1) == 1) begin
        bus.in_valid = 1'b1;
        bus.fixin    = 10'($urandom_range(0, 1023));
        bus.max_exp  = 4'($urandom_range(0, 15));
      end
      bus.out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      fired = bus.in_valid & bus.in_ready;
      @(posedge clk);
      #1;
      if (fired) begin
        sent++;
        bus.in_valid = 1'b0;
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("bp_sent", sent, 16);
    for (int i = 0; i < 60 && (sb.size() != 0 || bus.out_valid); i++) begin
      @(posedge clk);
      #1;
    end
    check("bp_drain", sb.size(), 0);

    // Mid-stream reset with three words in flight.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.fixin = 10'd176;  bus.max_exp = 4'd5; @(posedge clk); #1;
    bus.fixin = 10'h350;  bus.max_exp = 4'd5; @(posedge clk); #1;
    bus.fixin = 10'd188;  bus.max_exp = 4'd5; @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("inflight_valid", int'(bus.out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", int'(bus.out_valid), 0);
    check("async_rst_sfp", int'(bus.sfpout), 0);
    check("async_rst_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    run_vec("post_rst", 10'd252, 4'd5, RND ? 11'h070 : 11'h06F);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) cnt++;
    end
    check("no_stale_words", cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
